// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage plus the IF/ID pipeline register of the RISC-V core.
// The PC addresses an asynchronous instruction memory. The returned word and
// its PC are captured into IF/ID. Redirects from EX, load-use stalls and the
// HALT drain sequence are handled here.
//
// Ports
//   clk         : single clock, all state on the rising edge
//   reset       : asynchronous, active-high
//   Stall       : load-use stall, holds PC and IF/ID
//   PCSel       : redirect request from EX (taken branch / JAL / JALR)
//   BrPC        : redirect target (low two bits ignored)
//   imem_addr   : instruction memory address (= PC, combinational)
//   imem_rdata  : instruction word at imem_addr, same cycle
//   IFID_PC     : PC of the instruction held in IF/ID
//   IFID_Instr  : instruction held in IF/ID
//   IFID_Valid  : IF/ID holds a real instruction (0 for bubbles)
//   Opcode      : IFID_Instr[6:0], to the main decoder
//   halted      : core has stopped after draining
module fetch_stage #(
  parameter int unsigned     PC_W         = 9,
  parameter int unsigned     INST_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int unsigned     DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              PCSel,
  input  logic [PC_W-1:0]   BrPC,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   IFID_PC,
  output logic [INST_W-1:0] IFID_Instr,
  output logic              IFID_Valid,
  output logic [6:0]        Opcode,
  output logic              halted
);

  localparam int unsigned       CNT_W   = $clog2(DRAIN_CYCLES + 1);
  localparam logic [INST_W-1:0] BUBBLE  = INST_W'(32'h0000_0013);
  localparam logic [6:0]        HALT_OP = 7'b100_0000;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t             state;
  logic [CNT_W-1:0]   drain_cnt;
  logic [PC_W-1:0]    pc_p0;
  logic [PC_W-1:0]    ifid_pc_p1;
  logic [INST_W-1:0]  ifid_instr_p1;
  logic               vld_p1;
  logic               halted_q;
  logic               halt_in_ifid;

  // Redirect targets are always word aligned; the low two bits are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction

  // Sequential PC step; wraps silently at 2^PC_W.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] a);
    return a + PC_W'(4);
  endfunction

  assign halt_in_ifid = vld_p1 && (ifid_instr_p1[6:0] == HALT_OP);

  // ---- IF (p0) -> IF/ID (p1) boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      drain_cnt     <= '0;
      pc_p0         <= RESET_PC;
      ifid_pc_p1    <= '0;
      ifid_instr_p1 <= BUBBLE;
      vld_p1        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (PCSel) begin
            // The wrong-path word fetched this cycle is killed.
            pc_p0         <= align_pc(BrPC);
            ifid_instr_p1 <= BUBBLE;
            vld_p1        <= 1'b0;
          end else if (halt_in_ifid) begin
            // PC stays on the first un-issued instruction.
            ifid_instr_p1 <= BUBBLE;
            vld_p1        <= 1'b0;
            drain_cnt     <= CNT_W'(DRAIN_CYCLES - 1);
            state         <= DRAIN;
          end else if (!Stall) begin
            ifid_pc_p1    <= pc_p0;
            ifid_instr_p1 <= imem_rdata;
            vld_p1        <= 1'b1;
            pc_p0         <= next_pc(pc_p0);
          end
        end
        DRAIN: begin
          // Instructions ahead of HALT are past EX, so PCSel/Stall are moot.
          ifid_instr_p1 <= BUBBLE;
          vld_p1        <= 1'b0;
          if (drain_cnt == '0) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        HALTED: begin
          // Frozen until reset.
        end
        default: state <= RUN;
      endcase
    end
  end

  assign imem_addr  = pc_p0;
  assign IFID_PC    = ifid_pc_p1;
  assign IFID_Instr = ifid_instr_p1;
  assign IFID_Valid = vld_p1;
  assign Opcode     = ifid_instr_p1[6:0];
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int DRAIN = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Stall = 1'b0;
  logic        PCSel = 1'b0;
  logic [8:0]  BrPC = '0;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [8:0]  IFID_PC;
  logic [31:0] IFID_Instr;
  logic        IFID_Valid;
  logic [6:0]  Opcode;
  logic        halted;

  logic [31:0] mem [128];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural view of the fetch stage.
  logic [8:0]  m_pc;
  logic [8:0]  m_ifpc;
  logic [31:0] m_instr;
  logic        m_vld;
  logic        m_halted;
  int          m_drain_left;

  fetch_stage #(.PC_W(9), .INST_W(32), .RESET_PC(9'h000), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .PCSel(PCSel), .BrPC(BrPC),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .IFID_PC(IFID_PC),
    .IFID_Instr(IFID_Instr), .IFID_Valid(IFID_Valid), .Opcode(Opcode),
    .halted(halted)
  );

  assign imem_rdata = mem[imem_addr[8:2]];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 9'h000; m_ifpc = 9'h000; m_instr = 32'h13; m_vld = 1'b0;
    m_halted = 1'b0; m_drain_left = 0;
  endtask

  // One rising edge of the reference model.
  task automatic model_edge(input logic s, input logic p, input logic [8:0] b);
    if (m_halted) begin
      // nothing moves
    end else if (m_drain_left > 0) begin
      m_instr = 32'h13; m_vld = 1'b0;
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1'b1;
    end else if (p) begin
      m_pc = b & 9'h1FC;
      m_instr = 32'h13; m_vld = 1'b0;
    end else if (m_vld && m_instr[6:0] == 7'h40) begin
      m_instr = 32'h13; m_vld = 1'b0;
      m_drain_left = DRAIN;
    end else if (!s) begin
      m_ifpc = m_pc; m_instr = mem[m_pc / 4]; m_vld = 1'b1;
      m_pc = 9'((int'(m_pc) + 4) % 512);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},   32'(imem_addr),  32'(m_pc));
    chk({tag, ".vld"},    32'(IFID_Valid), 32'(m_vld));
    chk({tag, ".instr"},  IFID_Instr,      m_instr);
    chk({tag, ".opcode"}, 32'(Opcode),     32'(m_instr[6:0]));
    chk({tag, ".halted"}, 32'(halted),     32'(m_halted));
    if (m_vld) chk({tag, ".ifpc"}, 32'(IFID_PC), 32'(m_ifpc));
  endtask

  // Called between edges: drive, take one edge, compare just after it.
  task automatic step(input string tag, input logic s, input logic p, input logic [8:0] b);
    Stall = s; PCSel = p; BrPC = b;
    @(posedge clk);
    model_edge(s, p, b);
    #1;
    check_all(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".ifpc0"}, 32'(IFID_PC), 32'h0);
    check_all(tag);
  endtask

  initial begin
    logic [31:0] w;
    logic        rs, rp;
    logic [8:0]  rb;
    for (int i = 0; i < 128; i++) begin
      w = $urandom;
      if (w[6:0] == 7'h40) w[6] = 1'b0;
      mem[i] = w;
    end
    mem[0] = 32'h0010_0093;
    mem[1] = 32'h0020_0113;
    mem[2] = 32'h0030_0193;
    mem[3] = 32'h0040_0213;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    // Sequential fetch of 0,4,8
    step("seq0", 0, 0, 0); chk("seq0.ifpc", 32'(IFID_PC), 0);  chk("seq0.addr4", 32'(imem_addr), 4);
    step("seq1", 0, 0, 0); chk("seq1.ifpc", 32'(IFID_PC), 4);  chk("seq1.op", 32'(Opcode), 32'h13);
    step("seq2", 0, 0, 0); chk("seq2.ifpc", 32'(IFID_PC), 8);  chk("seq2.addr12", 32'(imem_addr), 12);
    step("seq3", 0, 0, 0);

    // Redirect at PC=0x010 to 0x043 (aligned to 0x040)
    chk("redir.pc_before", 32'(imem_addr), 32'h010);
    step("redir", 0, 1, 9'h043);
    chk("redir.addr", 32'(imem_addr), 32'h040); chk("redir.bubble", 32'(IFID_Valid), 0);
    step("redir_tgt", 0, 0, 0);
    chk("redir.ifpc", 32'(IFID_PC), 32'h040);

    // Stall two cycles at PC=8, then stall+redirect
    step("to4", 0, 1, 9'h004);
    step("f4", 0, 0, 0);
    chk("stall.pc8", 32'(imem_addr), 8);
    step("stall1", 1, 0, 0); chk("stall1.pc", 32'(imem_addr), 8); chk("stall1.ifpc", 32'(IFID_PC), 4);
    step("stall2", 1, 0, 0); chk("stall2.pc", 32'(imem_addr), 8); chk("stall2.ifpc", 32'(IFID_PC), 4);
    step("stall_end", 0, 0, 0); chk("stall_end.ifpc", 32'(IFID_PC), 8);
    step("stall_redir", 1, 1, 9'h0A0); chk("stall_redir.addr", 32'(imem_addr), 32'h0A0);

    // Randomized traffic (no HALT words in memory)
    for (int i = 0; i < 300; i++) begin
      rs = ($urandom_range(0, 3) == 0);
      rp = ($urandom_range(0, 7) == 0);
      rb = 9'($urandom);
      step("rand", rs, rp, rb);
    end

    // PC wrap
    step("wrap_redir", 0, 1, 9'h1FC);
    step("wrap", 0, 0, 0);
    chk("wrap.addr", 32'(imem_addr), 0); chk("wrap.ifpc", 32'(IFID_PC), 32'h1FC);

    // HALT squashed by a same-cycle redirect
    mem[32'h80 / 4] = 32'hABC0_0040;
    step("sq_redir", 0, 1, 9'h080);
    step("sq_halt_in", 0, 0, 0);
    chk("sq.op40", 32'(Opcode), 32'h40);
    step("sq_kill", 0, 1, 9'h020);
    chk("sq.addr", 32'(imem_addr), 32'h020);
    for (int i = 0; i < 5; i++) begin
      step("sq_run", 0, 0, 0);
      chk("sq.not_halted", 32'(halted), 0);
    end

    // HALT at address 12, full drain with PCSel noise
    mem[3] = 32'h0000_0040;
    step("h_redir", 0, 1, 9'h00C);
    step("h_in", 0, 0, 0);
    chk("h.op", 32'(Opcode), 32'h40); chk("h.addr16", 32'(imem_addr), 16);
    step("h_detect", 0, 0, 0);
    chk("h.detect_bubble", 32'(IFID_Valid), 0);
    for (int k = 0; k < DRAIN; k++) begin
      rp = $urandom_range(0, 1);
      rs = $urandom_range(0, 1);
      step("h_drain", rs, rp, 9'h100);
      chk("h.halted_time", 32'(halted), 32'(k == DRAIN - 1));
      chk("h.pc_frozen", 32'(imem_addr), 16);
    end
    for (int i = 0; i < 3; i++) begin
      step("h_halted", 0, 1, 9'h0C0);
      chk("h.stays", 32'(halted), 1); chk("h.pc_stays", 32'(imem_addr), 16);
    end

    // Async reset from HALTED
    #2 reset = 1'b1;
    model_reset();
    #1 chk("rst_halted.halted", 32'(halted), 0);
    check_reset_vals("rst_halted");
    reset = 1'b0;

    // Async reset mid-DRAIN
    step("d_redir", 0, 1, 9'h00C);
    step("d_in", 0, 0, 0);
    step("d_detect", 0, 0, 0);
    step("d_drain", 0, 0, 0);
    #2 reset = 1'b1;
    model_reset();
    #1 check_reset_vals("rst_drain");
    reset = 1'b0;
    step("post_rst", 0, 0, 0);
    chk("post_rst.ifpc", 32'(IFID_PC), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
